// File: rtl/dual_pwm_driver.sv
// Purpose: pitch/yaw edge-aligned PWM + direction generator for two H-bridges; optional PWM_WATCHDOG_EN command timeout.
// Latency: command sampled at the period boundary (cnt==PERIOD-1), visible from the next cnt==0; a reversal adds DEAD_PERIODS idle periods.
// Backpressure: none; command words are level inputs sampled only at boundaries, cmd_valid only feeds the watchdog.
module dual_pwm_driver #(
  parameter int PERIOD       = 2500,
  parameter int CNT_W        = 12,
  parameter int DEAD_PERIODS = 2,
  parameter int WDT_PERIODS  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pitch_pwm,
  input  logic [15:0] yaw_pwm,
  input  logic        cmd_valid,
  output logic        pitch_pwm_o,
  output logic        pitch_dir_o,
  output logic        yaw_pwm_o,
  output logic        yaw_dir_o,
  output logic        period_start,
  output logic        wdt_trip
);

  // Magnitude may equal PERIOD (saturated), which can need one bit more than the counter.
  localparam int MAG_W = CNT_W + 1;
  localparam int DC_W  = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  // Channel 0 = pitch, channel 1 = yaw.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_boundary;
  logic             r_period_start;
  logic             w_wdt_block;

  state_t           r_state     [2];
  state_t           w_state_nxt [2];
  logic [MAG_W-1:0] r_mag       [2];
  logic [MAG_W-1:0] w_mag_nxt   [2];
  logic [MAG_W-1:0] w_mag_new   [2];
  logic [DC_W-1:0]  r_dead      [2];
  logic [DC_W-1:0]  w_dead_nxt  [2];
  logic [15:0]      w_cmd       [2];
  logic [1:0]       r_dir;
  logic [1:0]       w_dir_nxt;
  logic [1:0]       r_pwm;

  assign w_cmd[0] = pitch_pwm;
  assign w_cmd[1] = yaw_pwm;

  assign w_boundary = (r_cnt == CNT_W'(PERIOD - 1));
  assign w_cnt_nxt  = w_boundary ? '0 : r_cnt + CNT_W'(1);

  // Clamp the 15-bit duty field to the period length.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [14:0] raw);
    if (int'({17'd0, raw}) >= PERIOD) return MAG_W'(PERIOD);
    return MAG_W'(raw);
  endfunction

  // Free-running period counter and its registered cnt==0 marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_period_start <= (w_cnt_nxt == '0);
    end
  end

`ifdef PWM_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_PERIODS + 1);

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_wdt_trip;
  logic             w_trip_now;

  // A cmd_valid landing on the expiry boundary suppresses the trip.
  assign w_trip_now  = w_boundary && !cmd_valid && !r_wdt_trip &&
                       (r_wdt_cnt == WDT_W'(WDT_PERIODS - 1));
  assign w_wdt_block = r_wdt_trip | w_trip_now;

  // Boundary-counting command timeout; any cmd_valid restarts it and releases a trip.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else if (cmd_valid) begin
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else if (w_boundary && !r_wdt_trip) begin
      r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
      if (w_trip_now) r_wdt_trip <= 1'b1;
    end
  end

  assign wdt_trip = r_wdt_trip;
`else
  logic [32:0] w_unused_wdt;

  assign w_unused_wdt = {cmd_valid, 32'(WDT_PERIODS)};
  assign w_wdt_block  = 1'b0;
  assign wdt_trip     = 1'b0;
`endif

  // Per-channel next-state: commands are only looked at on the boundary cycle.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_state_nxt[c] = r_state[c];
      w_mag_nxt[c]   = r_mag[c];
      w_dead_nxt[c]  = r_dead[c];
      w_dir_nxt[c]   = r_dir[c];
      w_mag_new[c]   = sat_mag(w_cmd[c][14:0]);
      if (w_boundary) begin
        if (w_wdt_block) begin
          // Timeout: zero duty, keep direction, never enter DEAD.
          w_state_nxt[c] = ST_RUN;
          w_mag_nxt[c]   = '0;
        end else begin
          case (r_state[c])
            ST_RUN: begin
              if (w_cmd[c][15] == r_dir[c]) begin
                w_mag_nxt[c] = w_mag_new[c];
              end else begin
                w_mag_nxt[c]   = '0;
                w_dead_nxt[c]  = DC_W'(DEAD_PERIODS - 1);
                w_state_nxt[c] = ST_DEAD;
              end
            end
            ST_DEAD: begin
              if (r_dead[c] != '0) begin
                w_dead_nxt[c] = r_dead[c] - DC_W'(1);
              end else begin
                w_dir_nxt[c]   = w_cmd[c][15];
                w_mag_nxt[c]   = w_mag_new[c];
                w_state_nxt[c] = ST_RUN;
              end
            end
            default: w_state_nxt[c] = ST_RUN;
          endcase
        end
      end
    end
  end

  // Channel state registers; PWM compares the next count against the next magnitude so it lines up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= ST_RUN;
        r_mag[c]   <= '0;
        r_dead[c]  <= '0;
      end
      r_dir <= '0;
      r_pwm <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_mag[c]   <= w_mag_nxt[c];
        r_dead[c]  <= w_dead_nxt[c];
        r_pwm[c]   <= ({1'b0, w_cnt_nxt} < w_mag_nxt[c]);
      end
      r_dir <= w_dir_nxt;
    end
  end

  assign pitch_pwm_o  = r_pwm[0];
  assign pitch_dir_o  = r_dir[0];
  assign yaw_pwm_o    = r_pwm[1];
  assign yaw_dir_o    = r_dir[1];
  assign period_start = r_period_start;

endmodule
